// File: rtl/memory_read_responder_pkg.sv
// Shared types, state encodings and helpers for memory_read_responder.
package memory_read_responder_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STATE_W = 2;

    typedef logic [XLEN-1:0]    regval_t;
    typedef logic [STATE_W-1:0] resp_state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQUEST   = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA = 2'd2;
    localparam logic [1:0] ST_RESPOND   = 2'd3;

    // Registered Avalon-MM read command
    typedef struct packed {
        logic    read;
        regval_t address;
    } avm_req_t;

    // Clear the low lsb bits so the result addresses a whole word
    function automatic regval_t word_align(input regval_t addr, input int unsigned lsb);
        regval_t mask;
        mask = ~((regval_t'(1) << lsb) - regval_t'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/memory_read_responder_bus_timeout_counter.sv
// Counts cycles while count is high; expired rises after TIMEOUT_CYCLES counted cycles.
module bus_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (clear) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (count && !expired) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_read_responder.sv
// Turns level-held pipeline read requests into single Avalon-MM reads and holds the result.
// Optional read timeout with sticky bus_error: define MEMORY_READ_RESPONDER_TIMEOUT_EN.
module memory_read_responder
    import memory_read_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_LSB       = 2
) (
    input  logic    clock,
    input  logic    reset_n,
    input  logic    address_enable,
    input  regval_t address,
    output logic    data_valid,
    output regval_t data,
    input  logic    invalidate,
    input  regval_t invalidate_address,
    output logic    avm_read,
    output regval_t avm_address,
    input  logic    avm_waitrequest,
    input  logic    avm_readdatavalid,
    input  regval_t avm_readdata,
    output logic    bus_error
);

    resp_state_t state, state_nxt;
    regval_t     latched, latched_nxt;
    logic        stale, stale_nxt;
    avm_req_t    req, req_nxt;
    regval_t     data_q, data_nxt;
    logic        bus_error_q, bus_error_nxt;

    logic        same_word;
    logic        inv_match;
    logic        abandon;
    logic        timeout_hit;
    logic        done;
    regval_t     done_data;

    assign same_word = (word_align(address, ADDR_LSB) == word_align(latched, ADDR_LSB));
    assign inv_match = invalidate &&
                       (word_align(invalidate_address, ADDR_LSB) == word_align(latched, ADDR_LSB));
    // Requester no longer wants the in-flight word, or a store just overwrote it
    assign abandon   = !address_enable || !same_word || inv_match;

`ifdef MEMORY_READ_RESPONDER_TIMEOUT_EN
    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (state != ST_WAIT_DATA),
        .count   (state == ST_WAIT_DATA),
        .expired (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            latched     <= '0;
            stale       <= 1'b0;
            req         <= '0;
            data_q      <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            latched     <= latched_nxt;
            stale       <= stale_nxt;
            req         <= req_nxt;
            data_q      <= data_nxt;
            bus_error_q <= bus_error_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        latched_nxt   = latched;
        stale_nxt     = stale;
        req_nxt       = req;
        data_nxt      = data_q;
        bus_error_nxt = bus_error_q;
        done          = 1'b0;
        done_data     = '0;

        case (state)
            ST_IDLE: begin
                if (address_enable) begin
                    latched_nxt     = address;
                    req_nxt.read    = 1'b1;
                    req_nxt.address = word_align(address, ADDR_LSB);
                    state_nxt       = ST_REQUEST;
                end
            end
            ST_REQUEST: begin
                if (abandon) begin
                    stale_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    req_nxt.read = 1'b0;
                    state_nxt    = ST_WAIT_DATA;
                    if (avm_readdatavalid) begin
                        done      = 1'b1;
                        done_data = avm_readdata;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (abandon) begin
                    stale_nxt = 1'b1;
                end
                if (avm_readdatavalid) begin
                    done      = 1'b1;
                    done_data = avm_readdata;
                end else if (timeout_hit) begin
                    done          = 1'b1;
                    done_data     = '0;
                    bus_error_nxt = 1'b1;
                end
            end
            ST_RESPOND: begin
                if (inv_match || !address_enable) begin
                    state_nxt = ST_IDLE;
                end else if (!same_word) begin
                    latched_nxt     = address;
                    req_nxt.read    = 1'b1;
                    req_nxt.address = word_align(address, ADDR_LSB);
                    state_nxt       = ST_REQUEST;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Completed transaction: deliver, or drop and let IDLE refetch next cycle
        if (done) begin
            if (stale || abandon) begin
                stale_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end else begin
                data_nxt  = done_data;
                state_nxt = ST_RESPOND;
            end
        end
    end

    assign data_valid  = (state == ST_RESPOND) && address_enable && same_word && !stale;
    assign data        = data_q;
    assign avm_read    = req.read;
    assign avm_address = req.address;
`ifdef MEMORY_READ_RESPONDER_TIMEOUT_EN
    assign bus_error   = bus_error_q;
`else
    assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_read_responder.sv
// Directed self-checking bench for memory_read_responder.
module tb_memory_read_responder;

`ifdef MEMORY_READ_RESPONDER_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clock;
    logic        reset_n;
    logic        address_enable;
    logic [31:0] address;
    logic        data_valid;
    logic [31:0] data;
    logic        invalidate;
    logic [31:0] invalidate_address;
    logic        avm_read;
    logic [31:0] avm_address;
    logic        avm_waitrequest;
    logic        avm_readdatavalid;
    logic [31:0] avm_readdata;
    logic        bus_error;

    int n_cmp;
    int n_err;
    int accepts;

    memory_read_responder #(
        .TIMEOUT_CYCLES (TMO),
        .ADDR_LSB       (2)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .address_enable     (address_enable),
        .address            (address),
        .data_valid         (data_valid),
        .data               (data),
        .invalidate         (invalidate),
        .invalidate_address (invalidate_address),
        .avm_read           (avm_read),
        .avm_address        (avm_address),
        .avm_waitrequest    (avm_waitrequest),
        .avm_readdatavalid  (avm_readdatavalid),
        .avm_readdata       (avm_readdata),
        .bus_error          (bus_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset_n && avm_read && !avm_waitrequest) accepts <= accepts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; accepts = 0;
        reset_n = 1'b0; address_enable = 1'b0; address = '0;
        invalidate = 1'b0; invalidate_address = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;

        // Reset state
        next(); next(); #1;
        chk("rst_dv", 32'(data_valid), 32'd0);
        chk("rst_rd", 32'(avm_read), 32'd0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_data", data, 32'h0);
        chk("rst_err", 32'(bus_error), 32'd0);
        next(); reset_n = 1'b1;
        next(); #1;
        chk("post_rst_dv", 32'(data_valid), 32'd0);

        // Zero-wait read of 0x100, data_valid in cycle 3
        address_enable = 1'b1; address = 32'h100; #1;
        chk("t1_c0_dv", 32'(data_valid), 32'd0);
        chk("t1_c0_rd", 32'(avm_read), 32'd0);
        next(); #1;
        chk("t1_c1_rd", 32'(avm_read), 32'd1);
        chk("t1_c1_addr", avm_address, 32'h100);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'hDEADBEEF; #1;
        chk("t1_c2_rd", 32'(avm_read), 32'd0);
        chk("t1_c2_dv", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("t1_c3_dv", 32'(data_valid), 32'd1);
        chk("t1_c3_data", data, 32'hDEADBEEF);
        chk("t1_accepts", 32'(accepts), 32'd1);

        // Non-matching invalidate is ignored
        next(); invalidate = 1'b1; invalidate_address = 32'h104; #1;
        chk("inv_nm_dv0", 32'(data_valid), 32'd1);
        next(); invalidate = 1'b0; #1;
        chk("inv_nm_dv1", 32'(data_valid), 32'd1);

        // Matching invalidate (0x102 is in word 0x100) forces refetch
        next(); invalidate = 1'b1; invalidate_address = 32'h102; #1;
        chk("inv_m_dv0", 32'(data_valid), 32'd1);
        next(); invalidate = 1'b0; #1;
        chk("inv_m_dv1", 32'(data_valid), 32'd0);
        chk("inv_m_rd1", 32'(avm_read), 32'd0);
        next(); #1;
        chk("inv_m_rd2", 32'(avm_read), 32'd1);
        chk("inv_m_addr2", avm_address, 32'h100);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'h12345678; #1;
        chk("inv_m_dv3", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("inv_m_dv4", 32'(data_valid), 32'd1);
        chk("inv_m_data4", data, 32'h12345678);
        chk("inv_accepts", 32'(accepts), 32'd2);

        // Same-word reuse: no bus traffic while held
        for (int i = 0; i < 5; i++) begin
            next(); #1;
            chk("hold_dv", 32'(data_valid), 32'd1);
            chk("hold_rd", 32'(avm_read), 32'd0);
        end
        chk("hold_accepts", 32'(accepts), 32'd2);
        next(); address = 32'h104; #1;
        chk("nw_dv0", 32'(data_valid), 32'd0);
        next(); #1;
        chk("nw_rd1", 32'(avm_read), 32'd1);
        chk("nw_addr1", avm_address, 32'h104);
        chk("nw_dv1", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFEF00D; #1;
        chk("nw_dv2", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("nw_dv3", 32'(data_valid), 32'd1);
        chk("nw_data3", data, 32'hCAFEF00D);
        chk("nw_accepts", 32'(accepts), 32'd3);

        // Waitrequest stall on unaligned 0x203
        next(); address_enable = 1'b0; #1;
        chk("st_dv0", 32'(data_valid), 32'd0);
        next(); address_enable = 1'b1; address = 32'h203; avm_waitrequest = 1'b1; #1;
        chk("st_rd_idle", 32'(avm_read), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next(); #1;
            chk("st_rd_hold", 32'(avm_read), 32'd1);
            chk("st_addr_hold", avm_address, 32'h200);
        end
        next(); avm_waitrequest = 1'b0; #1;
        chk("st_rd_acc", 32'(avm_read), 32'd1);
        chk("st_addr_acc", avm_address, 32'h200);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'h0BADF00D; #1;
        chk("st_rd_drop", 32'(avm_read), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("st_dv", 32'(data_valid), 32'd1);
        chk("st_data", data, 32'h0BADF00D);
        chk("st_accepts", 32'(accepts), 32'd4);

        // Flush in WAIT_DATA, then re-request of 0x300
        next(); address_enable = 1'b0;
        next(); address_enable = 1'b1; address = 32'h280;
        next(); #1;
        chk("fl_rd", 32'(avm_read), 32'd1);
        chk("fl_addr", avm_address, 32'h280);
        next(); address_enable = 1'b0; #1;
        chk("fl_dv_drop", 32'(data_valid), 32'd0);
        next(); address_enable = 1'b1; address = 32'h300; #1;
        chk("fl_dv_stale", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'hBAADBAAD; #1;
        chk("fl_dv_ret", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("fl_dv_idle", 32'(data_valid), 32'd0);
        chk("fl_data_kept", data, 32'h0BADF00D);
        chk("fl_rd_idle", 32'(avm_read), 32'd0);
        next(); #1;
        chk("fl_rd2", 32'(avm_read), 32'd1);
        chk("fl_addr2", avm_address, 32'h300);
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'h33333333; #1;
        chk("fl_dv3", 32'(data_valid), 32'd0);
        next(); avm_readdatavalid = 1'b0; #1;
        chk("fl_dv4", 32'(data_valid), 32'd1);
        chk("fl_data4", data, 32'h33333333);
        chk("fl_accepts", 32'(accepts), 32'd6);
        chk("fl_err", 32'(bus_error), 32'd0);

`ifdef MEMORY_READ_RESPONDER_TIMEOUT_EN
        // Timeout: no readdatavalid, respond with zero and sticky bus_error
        next(); address_enable = 1'b0;
        next(); address_enable = 1'b1; address = 32'h400;
        next(); #1;
        chk("to_rd", 32'(avm_read), 32'd1);
        for (int i = 0; i < 9; i++) begin
            next(); #1;
            chk("to_wait_dv", 32'(data_valid), 32'd0);
        end
        next(); #1;
        chk("to_dv", 32'(data_valid), 32'd1);
        chk("to_data", data, 32'h0);
        chk("to_err", 32'(bus_error), 32'd1);
        next(); address_enable = 1'b0;
        next(); avm_readdatavalid = 1'b1; avm_readdata = 32'h44444444;
        next(); avm_readdatavalid = 1'b0; #1;
        chk("to_err_sticky", 32'(bus_error), 32'd1);
        chk("to_late_ignored", data, 32'h0);
        reset_n = 1'b0; #2;
        chk("to_err_rst", 32'(bus_error), 32'd0);
        next(); reset_n = 1'b1;
        next(); #1;
        chk("to_err_after", 32'(bus_error), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/memory_read_responder.md
Name: memory_read_responder

Overview:
- Responder end of the data-memory read handshake that the pipeline's memory-reading stage drives: address_enable/address in, data_valid/data out.
- Converts each level-held read request into one Avalon-MM-style read on the external memory bus.
- Returns the captured word and keeps it valid while the requester holds the same address.
- Sits between the core pipeline and the memory interconnect; one instance per core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT_DATA before abandoning a read (used only with the optional feature).
- ADDR_LSB, 2: low address bits forced to zero on avm_address (word alignment).

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address_enable  in  1  read request, held high until data_valid is seen.
- address  in  32 (regval_t)  byte address of the requested word.
- data_valid  out  1  requested word available this cycle.
- data  out  32 (regval_t)  returned word.
- invalidate  in  1  a store to invalidate_address is committing.
- invalidate_address  in  32  store address, compared at word granularity.
- avm_read  out  1  bus read strobe.
- avm_address  out  32  bus word address, low ADDR_LSB bits zero.
- avm_waitrequest  in  1  bus stall; hold avm_read and avm_address while high.
- avm_readdatavalid  in  1  read data returning.
- avm_readdata  in  32  returned bus data.
- bus_error  out  1  sticky timeout flag.

Interface decision: single clock `clock`; reset `reset_n` is asynchronous, active-low.

Behaviour:
- Reset:
  - state=IDLE; avm_read=0, avm_address=0, data=0, bus_error=0.
  - latched address=0, stale=0, timeout count=0.
  - data_valid is 0 during and immediately after reset.
- data_valid is combinational: (state==RESPOND) && address_enable && (address word == latched word) && !stale. All other outputs are registered.
- IDLE:
  - If address_enable: latch address, drive avm_read=1 and avm_address=aligned address next cycle, go to REQUEST.
- REQUEST:
  - Hold avm_read and avm_address stable while avm_waitrequest=1.
  - On avm_waitrequest=0: drop avm_read next cycle and go to WAIT_DATA.
  - If avm_readdatavalid also arrives in the accepting cycle: capture the data and go straight to RESPOND.
- WAIT_DATA:
  - On avm_readdatavalid: data<=avm_readdata, go to RESPOND.
- Minimum latency: request seen in cycle 0, zero-wait bus with data returned the cycle after acceptance gives data_valid in cycle 3.
- RESPOND:
  - Stay while address_enable is high and the address is unchanged; back-to-back reads of the same word reuse data with no bus traffic.
  - address_enable low: go to IDLE.
  - address_enable high with a new word: latch it and go to REQUEST (avm_read next cycle).
- Requester abandons the request (flush: enable drops or address changes) while in REQUEST/WAIT_DATA:
  - Set stale=1; the bus transaction must still complete.
  - On completion: discard the data and clear stale.
  - Then re-request if address_enable is high, else go to IDLE.
- invalidate:
  - Matching the latched word in RESPOND: go to IDLE (forces a refetch).
  - Matching in REQUEST/WAIT_DATA: set stale.
  - Non-matching: ignored.
- Simultaneous avm_readdatavalid and matching invalidate: invalidate wins (data discarded, refetch).
- A new address_enable in the same cycle data returns is handled next cycle; only one transaction is outstanding at a time.

Optional Feature:
- Macro: MEMORY_READ_RESPONDER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DATA.
  - When it reaches TIMEOUT_CYCLES: data<=0, bus_error<=1 (sticky until reset), go to RESPOND.
  - A later late avm_readdatavalid is ignored while back in IDLE or RESPOND.
- Undefined:
  - WAIT_DATA waits indefinitely.
  - bus_error is tied to 0 and the counter is absent.

Decomposition:
- Shared package: regval_t (32-bit), word-align helper function, responder state enum (IDLE, REQUEST, WAIT_DATA, RESPOND).
- One sub-module, bus_timeout_counter:
  - Parameterised by TIMEOUT_CYCLES, width $clog2(TIMEOUT_CYCLES+1).
  - Inputs: clear, count. Output: expired.
  - Instantiated only under the macro.

Test Plan:
- Zero-wait read: enable, address=0x100; bus accepts immediately, readdata=0xDEADBEEF next cycle -> avm_address=0x100; data_valid=1, data=0xDEADBEEF in cycle 3.
- Waitrequest stall: waitrequest high 4 cycles, address=0x203 -> avm_read and avm_address=0x200 stable all 4 cycles; exactly one accepted read.
- Same-word reuse: hold 0x100 for 5 cycles after valid, then 0x104 -> no bus read during hold; new read for 0x104; data_valid low until it returns.
- Flush mid-flight: enable drops in WAIT_DATA, re-asserted for 0x300 before data returns -> old data never shown with data_valid=1; read of 0x300 follows completion.
- Invalidate: in RESPOND at 0x100, invalidate 0x102 -> data_valid drops next cycle; refetch returns new value 0x12345678.
- Timeout (macro on, TIMEOUT_CYCLES=8): no readdatavalid -> after 8 cycles data_valid=1, data=0, bus_error=1; stays 1 until reset_n pulse.
